// File: rtl/decode_ctrl_seq.sv
// decode_ctrl_seq
//   Decode-stage control unit. Turns the ID opcode into a registered ID/EX
//   control bundle, separates stall (hold) from flush (bubble), and runs a
//   MUL sequencer that freezes the front end through stall_req while a
//   multi-cycle multiply executes.
//
//   Ports:
//     clk, reset      rising-edge clock, synchronous active-high reset
//     stall, flush    hazard-unit hold / kill of the ID instruction
//     opcode          opcode from IF/ID
//     branch, jump    combinational decode of branch / jump opcodes
//     regwrite .. alusrc, mul_start   registered ID/EX control bundle
//     stall_req       registered, high while the MUL sequencer is busy
//     exc_illegal     registered illegal-opcode pulse
//
//   Optional feature: define CTRL_ILLEGAL_EXC_EN to raise exc_illegal for
//   one cycle when an unlisted opcode is decoded; otherwise it is tied 0.
//
//   state | meaning
//   IDLE  | normal decode
//   BUSY  | MUL executing; bundle is a bubble, cnt_q counts down to 1

`ifndef OP_RTYPE
`define OP_RTYPE 6'd0
`define OP_LDB   6'd32
`define OP_LDW   6'd35
`define OP_STB   6'd40
`define OP_STW   6'd43
`define OP_BEQ   6'd4
`define OP_BNE   6'd5
`define OP_JUMP  6'd2
`define OP_LI    6'd12
`define OP_ADDI  6'd8
`define OP_LUI   6'd15
`define OP_ORI   6'd13
`define OP_MUL   6'd28
`define OP_STALL 6'd63
`endif

module decode_ctrl_seq #(
  parameter int OPCODE_W = 6,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                branch,
  output logic                jump,
  output logic                regwrite,
  output logic                memtoreg,
  output logic                memwrite,
  output logic                memread,
  output logic [1:0]          memsize,
  output logic                alusrc,
  output logic                mul_start,
  output logic                stall_req,
  output logic                exc_illegal
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       mw;
    logic       mr;
    logic [1:0] size;
    logic       alusrc;
    logic       mul_start;
    logic       exc;
  } bundle_t;

  localparam logic            MUL_MULTI = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bundle_t          bundle_q, bundle_d;
  bundle_t          dec;
  logic             is_mul;
  logic             busy_hold;

  always_comb begin
    dec    = '0;
    is_mul = 1'b0;
    case (opcode)
      `OP_RTYPE: begin dec.rw = 1'b1; dec.alusrc = 1'b1; end
      `OP_LDB:   begin dec.rw = 1'b1; dec.m2r = 1'b1; dec.mr = 1'b1; end
      `OP_LDW:   begin dec.rw = 1'b1; dec.m2r = 1'b1; dec.mr = 1'b1; dec.size = 2'b10; end
      `OP_STB:   dec.mw = 1'b1;
      `OP_STW:   begin dec.mw = 1'b1; dec.size = 2'b10; end
      `OP_BEQ, `OP_BNE: dec.alusrc = 1'b1;
      `OP_JUMP, `OP_STALL: dec = '0;
      `OP_LI, `OP_ADDI, `OP_LUI, `OP_ORI: dec.rw = 1'b1;
      `OP_MUL: begin
        dec.rw        = 1'b1;
        dec.alusrc    = 1'b1;
        dec.mul_start = 1'b1;
        is_mul        = 1'b1;
      end
      default: begin
`ifdef CTRL_ILLEGAL_EXC_EN
        dec.exc = 1'b1;
`else
        dec = '0;
`endif
      end
    endcase
  end

  assign branch = (opcode == `OP_BEQ) || (opcode == `OP_BNE);
  assign jump   = (opcode == `OP_JUMP);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bundle_d  = bundle_q;
    // The last BUSY cycle (cnt==1) behaves as normal decode so the
    // instruction waiting in ID issues on the BUSY->IDLE edge.
    busy_hold = (state_q == BUSY) && (cnt_q != CNT_ONE);
    if (flush) begin
      bundle_d = '0;
      state_d  = IDLE;
      cnt_d    = '0;
    end else begin
      // The countdown runs even under stall.
      if (state_q == BUSY) begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = IDLE;
      end
      if (stall) begin
        bundle_d.exc = 1'b0;
      end else if (busy_hold) begin
        bundle_d = '0;
      end else begin
        bundle_d = dec;
        if (is_mul && MUL_MULTI) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bundle_q <= bundle_d;
    end
  end

  assign regwrite    = bundle_q.rw;
  assign memtoreg    = bundle_q.m2r;
  assign memwrite    = bundle_q.mw;
  assign memread     = bundle_q.mr;
  assign memsize     = bundle_q.size;
  assign alusrc      = bundle_q.alusrc;
  assign mul_start   = bundle_q.mul_start;
  assign stall_req   = (state_q == BUSY);
  assign exc_illegal = bundle_q.exc;

endmodule

// File: tb/tb_decode_ctrl_seq.sv
`ifndef OP_RTYPE
`define OP_RTYPE 6'd0
`define OP_LDB   6'd32
`define OP_LDW   6'd35
`define OP_STB   6'd40
`define OP_STW   6'd43
`define OP_BEQ   6'd4
`define OP_BNE   6'd5
`define OP_JUMP  6'd2
`define OP_LI    6'd12
`define OP_ADDI  6'd8
`define OP_LUI   6'd15
`define OP_ORI   6'd13
`define OP_MUL   6'd28
`define OP_STALL 6'd63
`endif

module tb_decode_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset, stall, flush;
  logic [5:0] opcode;

  logic       branch, jump, regwrite, memtoreg, memwrite, memread, alusrc;
  logic       mul_start, stall_req, exc_illegal;
  logic [1:0] memsize;

  logic       branch1, jump1, regwrite1, memtoreg1, memwrite1, memread1, alusrc1;
  logic       mul_start1, stall_req1, exc_illegal1;
  logic [1:0] memsize1;

  // {rw,m2r,mw,mr,size[1:0],alusrc,mul_start,stall_req,exc}
  logic [9:0] obs, obs1;
  assign obs  = {regwrite, memtoreg, memwrite, memread, memsize, alusrc,
                 mul_start, stall_req, exc_illegal};
  assign obs1 = {regwrite1, memtoreg1, memwrite1, memread1, memsize1, alusrc1,
                 mul_start1, stall_req1, exc_illegal1};

  int vectors = 0;
  int miscompares = 0;

`ifdef CTRL_ILLEGAL_EXC_EN
  localparam logic [9:0] EXP_ILL = 10'b0000000001;
`else
  localparam logic [9:0] EXP_ILL = 10'b0000000000;
`endif

  always #5 clk = ~clk;

  decode_ctrl_seq #(.OPCODE_W(6), .MUL_LAT(4), .CNT_W(3)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .opcode(opcode),
    .branch(branch), .jump(jump), .regwrite(regwrite), .memtoreg(memtoreg),
    .memwrite(memwrite), .memread(memread), .memsize(memsize), .alusrc(alusrc),
    .mul_start(mul_start), .stall_req(stall_req), .exc_illegal(exc_illegal)
  );

  decode_ctrl_seq #(.OPCODE_W(6), .MUL_LAT(1), .CNT_W(3)) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .opcode(opcode),
    .branch(branch1), .jump(jump1), .regwrite(regwrite1), .memtoreg(memtoreg1),
    .memwrite(memwrite1), .memread(memread1), .memsize(memsize1), .alusrc(alusrc1),
    .mul_start(mul_start1), .stall_req(stall_req1), .exc_illegal(exc_illegal1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; opcode = `OP_LDW;
    step(); step();
    vectors++;
    if (obs !== 10'b0000000000) begin
      miscompares++; $display("FAIL reset_state: got %b expected %b", obs, 10'b0000000000);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (obs !== 10'b1101100000) begin
      miscompares++; $display("FAIL reset_release_ldw: got %b expected %b", obs, 10'b1101100000);
    end
  endtask

  task automatic test_stall();
    opcode = `OP_STB;
    step();
    vectors++;
    if (obs !== 10'b0010000000) begin
      miscompares++; $display("FAIL stb_decode: got %b expected %b", obs, 10'b0010000000);
    end
    stall = 1'b1; opcode = `OP_RTYPE;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (obs !== 10'b0010000000) begin
        miscompares++; $display("FAIL stall_hold_%0d: got %b expected %b", i, obs, 10'b0010000000);
      end
    end
    stall = 1'b0;
    step();
    vectors++;
    if (obs !== 10'b1000001000) begin
      miscompares++; $display("FAIL rtype_after_stall: got %b expected %b", obs, 10'b1000001000);
    end
    opcode = `OP_STW;
    step();
    vectors++;
    if (obs !== 10'b0010100000) begin
      miscompares++; $display("FAIL stw_decode: got %b expected %b", obs, 10'b0010100000);
    end
    opcode = `OP_LDB;
    step();
    vectors++;
    if (obs !== 10'b1101000000) begin
      miscompares++; $display("FAIL ldb_decode: got %b expected %b", obs, 10'b1101000000);
    end
  endtask

  task automatic test_mul();
    int sr_cycles;
    opcode = `OP_MUL;
    step();
    vectors++;
    if (obs !== 10'b1000001110) begin
      miscompares++; $display("FAIL mul_issue: got %b expected %b", obs, 10'b1000001110);
    end
    vectors++;
    if (obs1 !== 10'b1000001100) begin
      miscompares++; $display("FAIL mul_lat1_issue: got %b expected %b", obs1, 10'b1000001100);
    end
    sr_cycles = 1;
    opcode = `OP_ADDI;
    for (int i = 0; i < 2; i++) begin
      step();
      if (stall_req === 1'b1) sr_cycles++;
      vectors++;
      if (obs !== 10'b0000000010) begin
        miscompares++; $display("FAIL mul_busy_%0d: got %b expected %b", i, obs, 10'b0000000010);
      end
    end
    step();
    vectors++;
    if (obs !== 10'b1000000000) begin
      miscompares++; $display("FAIL mul_exit_addi: got %b expected %b", obs, 10'b1000000000);
    end
    vectors++;
    if (sr_cycles !== 3) begin
      miscompares++; $display("FAIL mul_stall_req_cycles: got %0d expected %0d", sr_cycles, 3);
    end
    vectors++;
    if (obs1 !== 10'b1000000000) begin
      miscompares++; $display("FAIL mul_lat1_no_busy: got %b expected %b", obs1, 10'b1000000000);
    end
  endtask

  task automatic test_back_to_back();
    opcode = `OP_MUL;
    step();
    vectors++;
    if (obs !== 10'b1000001110) begin
      miscompares++; $display("FAIL b2b_first: got %b expected %b", obs, 10'b1000001110);
    end
    step(); step();
    vectors++;
    if (obs !== 10'b0000000010) begin
      miscompares++; $display("FAIL b2b_busy: got %b expected %b", obs, 10'b0000000010);
    end
    step();
    vectors++;
    if (obs !== 10'b1000001110) begin
      miscompares++; $display("FAIL b2b_second: got %b expected %b", obs, 10'b1000001110);
    end
    opcode = `OP_RTYPE;
    step(); step();
    vectors++;
    if (obs !== 10'b0000000010) begin
      miscompares++; $display("FAIL b2b_second_busy: got %b expected %b", obs, 10'b0000000010);
    end
    step();
    vectors++;
    if (obs !== 10'b1000001000) begin
      miscompares++; $display("FAIL b2b_exit_rtype: got %b expected %b", obs, 10'b1000001000);
    end
  endtask

  task automatic test_flush_busy();
    opcode = `OP_MUL;
    step();
    opcode = `OP_ADDI;
    step();
    vectors++;
    if (obs !== 10'b0000000010) begin
      miscompares++; $display("FAIL flush_busy_pre: got %b expected %b", obs, 10'b0000000010);
    end
    flush = 1'b1;
    step();
    vectors++;
    if (obs !== 10'b0000000000) begin
      miscompares++; $display("FAIL flush_busy_abort: got %b expected %b", obs, 10'b0000000000);
    end
    flush = 1'b0;
    step();
    vectors++;
    if (obs !== 10'b1000000000) begin
      miscompares++; $display("FAIL flush_then_addi: got %b expected %b", obs, 10'b1000000000);
    end
  endtask

  task automatic test_branch();
    opcode = `OP_BNE;
    #1;
    vectors++;
    if ({branch, jump} !== 2'b10) begin
      miscompares++; $display("FAIL bne_comb: got %b expected %b", {branch, jump}, 2'b10);
    end
    step();
    vectors++;
    if (obs !== 10'b0000001000) begin
      miscompares++; $display("FAIL bne_bundle: got %b expected %b", obs, 10'b0000001000);
    end
    stall = 1'b1; flush = 1'b1; opcode = `OP_RTYPE;
    step();
    vectors++;
    if (obs !== 10'b0000000000) begin
      miscompares++; $display("FAIL flush_over_stall: got %b expected %b", obs, 10'b0000000000);
    end
    stall = 1'b0; flush = 1'b0; opcode = `OP_JUMP;
    #1;
    vectors++;
    if ({branch, jump} !== 2'b01) begin
      miscompares++; $display("FAIL jump_comb: got %b expected %b", {branch, jump}, 2'b01);
    end
    opcode = `OP_BEQ;
    #1;
    vectors++;
    if ({branch, jump} !== 2'b10) begin
      miscompares++; $display("FAIL beq_comb: got %b expected %b", {branch, jump}, 2'b10);
    end
    opcode = `OP_ORI;
    step();
    opcode = `OP_JUMP;
    step();
    vectors++;
    if (obs !== 10'b0000000000) begin
      miscompares++; $display("FAIL jump_bubble: got %b expected %b", obs, 10'b0000000000);
    end
  endtask

  task automatic test_reset_busy();
    opcode = `OP_MUL;
    step(); step();
    reset = 1'b1;
    step();
    vectors++;
    if (obs !== 10'b0000000000) begin
      miscompares++; $display("FAIL reset_mid_busy: got %b expected %b", obs, 10'b0000000000);
    end
    reset = 1'b0; opcode = `OP_RTYPE;
    step();
    vectors++;
    if (obs !== 10'b1000001000) begin
      miscompares++; $display("FAIL reset_busy_idle: got %b expected %b", obs, 10'b1000001000);
    end
  endtask

  task automatic test_illegal();
    opcode = 6'd51;
    step();
    vectors++;
    if (obs !== EXP_ILL) begin
      miscompares++; $display("FAIL illegal_decode: got %b expected %b", obs, EXP_ILL);
    end
    stall = 1'b1;
    step();
    vectors++;
    if (obs !== 10'b0000000000) begin
      miscompares++; $display("FAIL illegal_under_stall: got %b expected %b", obs, 10'b0000000000);
    end
    stall = 1'b0; opcode = `OP_STALL;
    step();
    vectors++;
    if (obs !== 10'b0000000000) begin
      miscompares++; $display("FAIL op_stall_bubble: got %b expected %b", obs, 10'b0000000000);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_mul();
    test_back_to_back();
    test_flush_busy();
    test_branch();
    test_reset_busy();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
